// File: rtl/noc_pkg.sv
// Shared flit layout and route-label encodings for the NoC router ports.
package noc_pkg;
  localparam int DATASIZE_DEF = 40;

  localparam int SRC_MSB  = 39;
  localparam int SRC_LSB  = 36;
  localparam int DST_MSB  = 35;
  localparam int DST_LSB  = 32;
  localparam int TS_MSB   = 31;
  localparam int TS_LSB   = 24;
  localparam int DATA_MSB = 23;
  localparam int DATA_LSB = 2;
  localparam int TYPE_MSB = 1;
  localparam int TYPE_LSB = 0;

  localparam logic [3:0] LBL_LOCAL = 4'b0000;
  localparam logic [3:0] LBL_NONE  = 4'b1111;

  // One-hot position of each output direction in the {W,N,E,S} label
  localparam int DIR_W = 3;
  localparam int DIR_N = 2;
  localparam int DIR_E = 1;
  localparam int DIR_S = 0;
endpackage

// File: rtl/xy_route_calc.sv
// XY dimension-order route: resolve x first, then y; all-zero label means eject locally.
module xy_route_calc
  import noc_pkg::*;
#(
  parameter int X_COORD = 0,
  parameter int Y_COORD = 0
) (
  input  logic [3:0] dst,
  output logic [3:0] label
);
  localparam logic [1:0] XC = 2'(X_COORD);
  localparam logic [1:0] YC = 2'(Y_COORD);

  logic [1:0] dx, dy;
  assign dx = dst[3:2];
  assign dy = dst[1:0];

  always_comb begin
    label = LBL_LOCAL;
    if (dx > XC)      label[DIR_E] = 1'b1;
    else if (dx < XC) label[DIR_W] = 1'b1;
    else if (dy > YC) label[DIR_N] = 1'b1;
    else if (dy < YC) label[DIR_S] = 1'b1;
  end
endmodule

// File: rtl/noc_input_port.sv
// Router input port: show-ahead flit FIFO with registered back-pressure and
// XY route label for the head flit.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 3,
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int X_COORD  = 0,
  parameter int Y_COORD  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  output logic                full,
  input  logic                ready,
  output logic [3:0]          label,
  output logic [DATASIZE-1:0] data_out,
  output logic [WIDTH:0]      count
);
  localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [WIDTH-1:0]    wr_ptr, rd_ptr;
  logic                empty, push, pop;
  logic [3:0]          route_lbl;

  // full comes only from the registered count so upstream sees no comb path
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign push  = in_valid & ~full;
  assign pop   = ready & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign data_out = empty ? '0 : mem[rd_ptr];

  xy_route_calc #(
    .X_COORD (X_COORD),
    .Y_COORD (Y_COORD)
  ) u_route (
    .dst   (data_out[DST_MSB:DST_LSB]),
    .label (route_lbl)
  );

  assign label = empty ? LBL_NONE : route_lbl;
endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port at router (1,1): queue-based reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_noc_input_port;
  localparam int DS = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DS-1:0] in_data;
  logic          full;
  logic          ready;
  logic [3:0]    label;
  logic [DS-1:0] data_out;
  logic [3:0]    count;

  noc_input_port #(
    .DEPTH(8), .WIDTH(3), .DATASIZE(DS), .X_COORD(1), .Y_COORD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .full(full), .ready(ready), .label(label), .data_out(data_out),
    .count(count)
  );

  always #5 clk = ~clk;

  logic [DS-1:0] q[$];     // reference FIFO contents, head at q[0]
  logic [DS-1:0] pend;     // flit held in the upstream output register
  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [DS-1:0] rnd_flit();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // XY routing from the rules, for a router at (1,1)
  function automatic logic [3:0] exp_label(input logic [3:0] dst);
    int dx, dy;
    dx = int'(dst[3:2]);
    dy = int'(dst[1:0]);
    if (dx > 1) return 4'b0010;
    if (dx < 1) return 4'b1000;
    if (dy > 1) return 4'b0100;
    if (dy < 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    int n;
    n = q.size();
    chk("count", 64'(count), 64'(n));
    chk("full", 64'(full), 64'(n == 8));
    chk("label", 64'(label), 64'((n == 0) ? 4'hf : exp_label(q[0][35:32])));
    chk("data_out", 64'(data_out), 64'((n == 0) ? '0 : q[0]));
  endtask

  // One clock: drive, check model at negedge, then advance model at posedge
  task automatic step(input bit v, input bit r, input bit rs);
    bit do_push, do_pop;
    in_valid = v;
    ready    = r;
    rst_n    = rs;
    in_data  = pend;
    @(negedge clk);
    chk_model();
    do_pop  = r && (q.size() != 0);
    do_push = v && (q.size() < 8);
    @(posedge clk);
    if (!rs) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(pend);
        pend = rnd_flit();
      end
    end
    #1;
  endtask

  logic [3:0] dsts [5] = '{4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
  logic [3:0] lbls [5] = '{4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b0000};

  initial begin
    logic [DS-1:0] f;
    pend = rnd_flit();
    step(0, 0, 0);
    step(0, 0, 0);

    // idle after reset with ready asserted
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    chk("rst_label", 64'(label), 64'(4'hf));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));

    // route label table, one flit at a time
    for (int i = 0; i < 5; i++) begin
      pend[35:32] = dsts[i];
      f = pend;
      step(1, 0, 1);
      chk("lbl_tbl", 64'(label), 64'(lbls[i]));
      chk("lbl_data", 64'(data_out), 64'(f));
      step(0, 1, 1);
    end

    // fill to full, then hold the 9th flit upstream
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_count", 64'(count), 64'(8));
    step(1, 0, 1);
    step(1, 0, 1);
    chk("held_count", 64'(count), 64'(8));
    step(1, 1, 1);  // pop only while full
    chk("popfull_count", 64'(count), 64'(7));
    chk("popfull_full", 64'(full), 64'(0));
    step(1, 0, 1);
    chk("refill_count", 64'(count), 64'(8));
    for (int i = 0; i < 9; i++) step(0, 1, 1);

    // steady streaming at depth 4, pointers wrap several times
    for (int i = 0; i < 4; i++) step(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 1);
      chk("stream_count", 64'(count), 64'(4));
    end
    for (int i = 0; i < 5; i++) step(0, 1, 1);

    // reset while holding five flits
    for (int i = 0; i < 5; i++) step(1, 0, 1);
    chk("pre_rst_count", 64'(count), 64'(5));
    step(0, 0, 0);
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_label", 64'(label), 64'(4'hf));
    chk("midrst_full", 64'(full), 64'(0));
    pend[35:32] = 4'b0101;
    step(1, 0, 1);
    chk("post_rst_label", 64'(label), 64'(4'b0000));
    step(0, 1, 1);

    // random traffic with rare resets
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 59) != 0);
    for (int i = 0; i < 9; i++) step(0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
